// File: rtl/turn_signal_sequencer.sv
// Taillight front-end: syncs/debounces switches, divides clk into the step tick, arbitrates one command.
// Latency: cmd follows its debounced trigger by 1 cycle; no backpressure, seq_done gates direction changes.
module turn_signal_sequencer #(
    parameter int SYSTEM_FREQ     = 12500,
    parameter int HZ              = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_TICKS   = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic left_sw,
    input  logic right_sw,
    input  logic haz_sw,
    input  logic seq_done,
    output logic tick,
    output logic left_cmd,
    output logic right_cmd,
    output logic haz_cmd,
    output logic timeout
);

    localparam int DIV = SYSTEM_FREQ / HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW  = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TOUT_MAX  = TW'(TIMEOUT_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEFT,
        ST_RIGHT,
        ST_HAZ
    } state_t;

    logic [2:0]          sync1_q, sync1_d;
    logic [2:0]          sync2_q, sync2_d;
    logic [2:0]          db_q, db_d;
    logic [2:0][DW-1:0]  db_cnt_q, db_cnt_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic                tick_q, tick_d;
    state_t              state_q, state_d;
    logic [TW-1:0]       tout_q, tout_d;
    logic                cancel_q, cancel_d;
    logic                left_cmd_q, left_cmd_d;
    logic                right_cmd_q, right_cmd_d;
    logic                haz_cmd_q, haz_cmd_d;
    logic                timeout_q, timeout_d;

    logic   left_db, right_db, haz_db;
    logic   turn_q;
    state_t target;

    assign left_db  = db_q[0];
    assign right_db = db_q[1];
    assign haz_db   = db_q[2];
    assign turn_q   = (state_q == ST_LEFT) || (state_q == ST_RIGHT);

    // Switch front-end: two-flop synchroniser then a per-switch stability counter.
    always_comb begin
        sync1_d  = {haz_sw, right_sw, left_sw};
        sync2_d  = sync1_q;
        db_d     = db_q;
        db_cnt_d = '0;
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    always_comb begin
        presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
        tick_d  = (presc_d == PRESC_MAX);
    end

    always_comb begin
        target = ST_IDLE;
        if (haz_db || (left_db && right_db)) begin
            target = ST_HAZ;
        end else if (left_db && !cancel_q) begin
            target = ST_LEFT;
        end else if (right_db && !cancel_q) begin
            target = ST_RIGHT;
        end

        // Hazard preempts at once; other direction changes wait for a sequence boundary.
        state_d = state_q;
        if (target == ST_HAZ) begin
            state_d = ST_HAZ;
        end else if (state_q == ST_IDLE) begin
            state_d = target;
        end else if (seq_done && (target != state_q)) begin
            state_d = target;
        end

        // A state change discards any tick landing on the same cycle.
        tout_d = tout_q;
        if (state_d != state_q) begin
            tout_d = '0;
        end else if (turn_q && tick_q && (tout_q != TOUT_MAX)) begin
            tout_d = tout_q + TW'(1);
        end

        cancel_d = cancel_q;
        if ((state_d == ST_HAZ) && (state_q != ST_HAZ)) begin
            cancel_d = 1'b0;
        end else if (turn_q && (tout_q == TOUT_MAX)) begin
            cancel_d = 1'b1;
        end else if (!left_db && !right_db) begin
            cancel_d = 1'b0;
        end

        timeout_d   = turn_q && (state_d == ST_IDLE) && (tout_q == TOUT_MAX);
        left_cmd_d  = (state_d == ST_LEFT);
        right_cmd_d = (state_d == ST_RIGHT);
        haz_cmd_d   = (state_d == ST_HAZ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            db_cnt_q    <= '0;
            presc_q     <= '0;
            tick_q      <= 1'b0;
            state_q     <= ST_IDLE;
            tout_q      <= '0;
            cancel_q    <= 1'b0;
            left_cmd_q  <= 1'b0;
            right_cmd_q <= 1'b0;
            haz_cmd_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            db_cnt_q    <= db_cnt_d;
            presc_q     <= presc_d;
            tick_q      <= tick_d;
            state_q     <= state_d;
            tout_q      <= tout_d;
            cancel_q    <= cancel_d;
            left_cmd_q  <= left_cmd_d;
            right_cmd_q <= right_cmd_d;
            haz_cmd_q   <= haz_cmd_d;
            timeout_q   <= timeout_d;
        end
    end

    assign tick      = tick_q;
    assign left_cmd  = left_cmd_q;
    assign right_cmd = right_cmd_q;
    assign haz_cmd   = haz_cmd_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_turn_signal_sequencer.sv
// Bench for turn_signal_sequencer at DIV=10, debounce 4, timeout 8 ticks; vector table plus reset corner.
module tb_turn_signal_sequencer;

    localparam int DIV = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic left_sw = 1'b0, right_sw = 1'b0, haz_sw = 1'b0, seq_done = 1'b0;
    logic tick, left_cmd, right_cmd, haz_cmd, timeout;

    turn_signal_sequencer #(
        .SYSTEM_FREQ    (80),
        .HZ             (8),
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_TICKS  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .left_sw  (left_sw),
        .right_sw (right_sw),
        .haz_sw   (haz_sw),
        .seq_done (seq_done),
        .tick     (tick),
        .left_cmd (left_cmd),
        .right_cmd(right_cmd),
        .haz_cmd  (haz_cmd),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        string    name;
        logic     l, r, h, sd;
        int       n;
        logic [3:0] exp;   // {left_cmd, right_cmd, haz_cmd, timeout}
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         tmod = 0;
    int         to_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // One clock: update the prescaler model, sample at the falling edge, check tick every cycle.
    task automatic cyc();
        @(posedge clk);
        if (!rst) tmod = (tmod + 1) % DIV;
        @(negedge clk);
        if (timeout === 1'b1) to_seen++;
        chk("tick", {31'd0, tick}, {31'd0, (!rst && tmod == DIV - 1)});
    endtask

    task automatic add(input string name, input logic l, input logic r, input logic h,
                       input logic sd, input int n, input logic [3:0] e);
        vec_t v;
        v.name = name; v.l = l; v.r = r; v.h = h; v.sd = sd; v.n = n; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] want;

        //  name              L  R  H  SD  cycles  {L,R,H,TO}
        add("idle_30",         0, 0, 0, 0, 30, 4'b0000);
        add("glitch_hi",       1, 0, 0, 0,  3, 4'b0000);
        add("glitch_gone",     0, 0, 0, 0, 10, 4'b0000);
        add("left_edge6",      1, 0, 0, 0,  6, 4'b0000);
        add("left_edge7",      1, 0, 0, 0,  1, 4'b1000);
        add("left_hold_swap",  0, 1, 0, 0, 20, 4'b1000);
        add("swap_at_done",    0, 1, 0, 1,  1, 4'b0100);
        add("right_stays",     0, 1, 0, 0,  1, 4'b0100);
        add("haz_edge6",       0, 1, 1, 0,  6, 4'b0100);
        add("haz_edge7",       0, 1, 1, 0,  1, 4'b0010);
        add("haz_hold",        0, 1, 0, 0, 30, 4'b0010);
        add("haz_to_right",    0, 1, 0, 1,  1, 4'b0100);
        add("right_hold_rel",  0, 0, 0, 0, 20, 4'b0100);
        add("right_exit",      0, 0, 0, 1,  1, 4'b0000);
        add("idle_again",      0, 0, 0, 0, 10, 4'b0000);
        add("left_on",         1, 0, 0, 0,  7, 4'b1000);
        add("left_long",       1, 0, 0, 0,100, 4'b1000);
        add("timeout_exit",    1, 0, 0, 1,  1, 4'b0001);
        add("timeout_1cyc",    1, 0, 0, 0,  1, 4'b0000);
        add("cancel_held",     1, 0, 0, 0, 30, 4'b0000);
        add("cancel_release",  0, 0, 0, 0, 10, 4'b0000);
        add("left_repress",    1, 0, 0, 0,  7, 4'b1000);
        add("left_rel_hold",   0, 0, 0, 0, 10, 4'b1000);
        add("left_exit_no_to", 0, 0, 0, 1,  1, 4'b0000);
        add("idle_gap",        0, 0, 0, 0,  5, 4'b0000);
        add("both_to_haz",     1, 1, 0, 0,  7, 4'b0010);

        // Reset state
        repeat (3) cyc();
        chk("reset_outs", {28'd0, left_cmd, right_cmd, haz_cmd, timeout}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            left_sw  = vecs[i].l;
            right_sw = vecs[i].r;
            haz_sw   = vecs[i].h;
            seq_done = vecs[i].sd;
            exp_q.push_back(vecs[i].exp);
            cyc();
            seq_done = 1'b0;
            for (int k = 1; k < vecs[i].n; k++) cyc();
            want = exp_q.pop_front();
            chk(vecs[i].name, {28'd0, left_cmd, right_cmd, haz_cmd, timeout}, {28'd0, want});
        end

        // Reset mid-hazard: outputs drop without waiting for a clock edge.
        rst  = 1'b1;
        tmod = 0;
        #1;
        chk("rst_async_outs", {27'd0, tick, left_cmd, right_cmd, haz_cmd, timeout}, 32'd0);
        repeat (2) cyc();
        chk("rst_held_outs", {28'd0, left_cmd, right_cmd, haz_cmd, timeout}, 32'd0);
        rst = 1'b0;
        repeat (6) cyc();
        chk("post_rst_edge6", {28'd0, left_cmd, right_cmd, haz_cmd, timeout}, 32'd0);
        cyc();
        chk("post_rst_edge7", {28'd0, left_cmd, right_cmd, haz_cmd, timeout}, 32'b0010);

        left_sw  = 1'b0;
        right_sw = 1'b0;
        repeat (10) cyc();
        chk("timeout_pulses", to_seen, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
